useq: RTL and testbench

USEQ -- requirements
Module: useq

---
 rtl/useq.sv | 133 +++++++++++++
 tb/tb_useq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/useq.sv
// Microprogram sequencer: walks a 23-bit microword ROM and issues control bits,
// with jump, conditional, counted-loop, start-wait and halt microinstructions.
module useq #(
  parameter logic [3:0] LOOP_INIT  = 4'd8,
  parameter logic [4:0] START_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  cond,
  output logic [4:0]  addr,
  input  logic [22:0] data,
  output logic [14:0] ctrl,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 15;
  localparam int unsigned NW = 4;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] SEL_JMP  = 3'd0;
  localparam logic [SW-1:0] SEL_C0   = 3'd1;
  localparam logic [SW-1:0] SEL_C1   = 3'd2;
  localparam logic [SW-1:0] SEL_C2   = 3'd3;
  localparam logic [SW-1:0] SEL_LOOP = 3'd4;
  localparam logic [SW-1:0] SEL_WAIT = 3'd5;
  localparam logic [SW-1:0] SEL_NEXT = 3'd6;
  localparam logic [SW-1:0] SEL_HALT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] mpc, mpc_nxt;
  logic [NW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] ctrl_nxt;
  logic          busy_nxt, done_nxt;

  logic [SW-1:0] sel;
  logic [AW-1:0] target;
  logic [CW-1:0] ctl;
  logic [AW-1:0] mpc_inc;

  // Microword field split; the increment wraps naturally at 5 bits.
  assign sel     = data[22:20];
  assign target  = data[19:15];
  assign ctl     = data[14:0];
  assign mpc_inc = mpc + AW'(1);

  assign addr = mpc;

  // State, microprogram counter, loop counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mpc   <= START_ADDR;
      cnt   <= '0;
      ctrl  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      mpc   <= mpc_nxt;
      cnt   <= cnt_nxt;
      ctrl  <= ctrl_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state, next-address and control issue.
  always_comb begin
    state_nxt = state;
    mpc_nxt   = mpc;
    cnt_nxt   = cnt;
    ctrl_nxt  = '0;
    case (state)
      IDLE: begin
        mpc_nxt = START_ADDR;
        if (start && !abort) begin
          state_nxt = RUN;
          cnt_nxt   = LOOP_INIT;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          mpc_nxt   = START_ADDR;
        end else if (sel == SEL_HALT) begin
          state_nxt = DONE;
        end else begin
          ctrl_nxt = ctl;
          case (sel)
            SEL_JMP:  mpc_nxt = target;
            SEL_C0:   mpc_nxt = cond[0] ? target : mpc_inc;
            SEL_C1:   mpc_nxt = cond[1] ? target : mpc_inc;
            SEL_C2:   mpc_nxt = cond[2] ? target : mpc_inc;
            SEL_LOOP: begin
              if (cnt != '0) begin
                mpc_nxt = target;
                cnt_nxt = cnt - NW'(1);
              end else begin
                mpc_nxt = mpc_inc;
              end
            end
            SEL_WAIT: mpc_nxt = start ? mpc_inc : target;
            SEL_NEXT: mpc_nxt = mpc_inc;
            default:  mpc_nxt = mpc;
          endcase
        end
      end
      DONE: begin
        if (abort || !start) begin
          state_nxt = IDLE;
          mpc_nxt   = START_ADDR;
        end
      end
      default: begin
        state_nxt = IDLE;
        mpc_nxt   = START_ADDR;
      end
    endcase
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_useq.sv
// Directed bench for useq: a ROM image held in the bench feeds data from addr,
// expected outputs are hand-computed per clock.
module tb_useq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  cond;
  logic [4:0]  addr;
  logic [22:0] data;
  logic [14:0] ctrl;
  logic        busy;
  logic        done;

  logic [22:0] rom [32];
  int n_run  = 0;
  int n_fail = 0;

  useq #(.LOOP_INIT(4'd3), .START_ADDR(5'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .cond  (cond),
    .addr  (addr),
    .data  (data),
    .ctrl  (ctrl),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  assign data = rom[addr];

  typedef struct {
    logic        start;
    logic        abort;
    logic [2:0]  cond;
    logic [4:0]  addr;
    logic [14:0] ctrl;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [22:0] mw(input logic [2:0] s, input logic [4:0] t, input logic [14:0] c);
    return {s, t, c};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = mw(3'd7, 5'd0, 15'h7FFF);
  endtask

  task automatic add(input logic s, input logic a, input logic [2:0] c,
                     input logic [4:0] ea, input logic [14:0] ec, input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.abort = a; v.cond = c;
    v.addr = ea; v.ctrl = ec; v.busy = eb; v.done = ed;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [4:0] ea, input logic [14:0] ec,
                     input logic eb, input logic ed);
    n_run++;
    if (addr !== ea || ctrl !== ec || busy !== eb || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d ctrl=%h busy=%b done=%b, want addr=%0d ctrl=%h busy=%b done=%b",
               name, addr, ctrl, busy, done, ea, ec, eb, ed);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic [2:0] c);
    start = s; abort = a; cond = c;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  lp_a [21] = '{5'd8, 5'd9, 5'd10, 5'd8, 5'd9, 5'd10, 5'd8, 5'd9, 5'd10, 5'd8, 5'd9,
                             5'd10, 5'd11, 5'd13, 5'd30, 5'd31, 5'd0, 5'd8, 5'd9, 5'd10, 5'd11};
  logic [14:0] lp_c [21] = '{15'h10, 15'h18, 15'h19, 15'h1A, 15'h18, 15'h19, 15'h1A, 15'h18, 15'h19,
                             15'h1A, 15'h18, 15'h19, 15'h1A, 15'h1B, 15'h1D, 15'h1E, 15'h1F,
                             15'h10, 15'h18, 15'h19, 15'h1A};

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cond = 3'd0;
    clear_rom();
    rom[0] = mw(3'd0, 5'd1, 15'h0A1);
    rom[1] = mw(3'd0, 5'd2, 15'h0A2);
    rom[2] = mw(3'd0, 5'd3, 15'h0A3);
    #12;
    chk("reset_state", 5'd0, 15'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight line, handshake, abort in IDLE/RUN/DONE
    add(1,0,0, 0, 15'h0,   1,0);
    add(0,0,0, 1, 15'h0A1, 1,0);
    add(0,0,0, 2, 15'h0A2, 1,0);
    add(0,0,0, 3, 15'h0A3, 1,0);
    add(0,0,0, 3, 15'h0,   0,1);
    add(0,0,0, 0, 15'h0,   0,0);
    add(1,1,0, 0, 15'h0,   0,0);
    add(1,0,0, 0, 15'h0,   1,0);
    add(1,0,0, 1, 15'h0A1, 1,0);
    add(1,0,0, 2, 15'h0A2, 1,0);
    add(1,0,0, 3, 15'h0A3, 1,0);
    add(1,0,0, 3, 15'h0,   0,1);
    add(1,0,0, 3, 15'h0,   0,1);
    add(0,0,0, 0, 15'h0,   0,0);
    add(1,0,0, 0, 15'h0,   1,0);
    add(0,0,0, 1, 15'h0A1, 1,0);
    add(0,0,0, 2, 15'h0A2, 1,0);
    add(0,1,0, 0, 15'h0,   0,0);
    add(0,0,0, 0, 15'h0,   0,0);
    add(1,0,0, 0, 15'h0,   1,0);
    add(0,0,0, 1, 15'h0A1, 1,0);
    add(0,0,0, 2, 15'h0A2, 1,0);
    add(0,0,0, 3, 15'h0A3, 1,0);
    add(1,0,0, 3, 15'h0,   0,1);
    add(1,1,0, 0, 15'h0,   0,0);
    add(0,0,0, 0, 15'h0,   0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].abort, tbl[i].cond);
      chk($sformatf("vec[%0d]", i), tbl[i].addr, tbl[i].ctrl, tbl[i].busy, tbl[i].done);
    end

    // Conditional branches on cond[0], cond[1], cond[2]
    clear_rom();
    rom[0]  = mw(3'd6, 5'd0,  15'h1);
    rom[1]  = mw(3'd6, 5'd0,  15'h2);
    rom[2]  = mw(3'd6, 5'd0,  15'h3);
    rom[3]  = mw(3'd1, 5'd12, 15'h4);
    rom[12] = mw(3'd3, 5'd20, 15'h5);
    rom[4]  = mw(3'd2, 5'd25, 15'h6);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] c;
      logic [4:0] a4, a5;
      logic [14:0] c4, c5;
      c  = (k == 0) ? 3'b101 : (k == 1) ? 3'b000 : 3'b010;
      a4 = (k == 0) ? 5'd12 : 5'd4;
      a5 = (k == 0) ? 5'd20 : (k == 1) ? 5'd5 : 5'd25;
      c5 = (k == 0) ? 15'h5 : 15'h6;
      c4 = 15'h4;
      step(1, 0, c); chk($sformatf("cond%0d_start", k), 0, 15'h0, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_w0", k), 1, 15'h1, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_w1", k), 2, 15'h2, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_w2", k), 3, 15'h3, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_w3", k), a4, c4, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_br2", k), a5, c5, 1, 0);
      step(0, 0, c); chk($sformatf("cond%0d_halt", k), a5, 15'h0, 0, 1);
      step(0, 0, c); chk($sformatf("cond%0d_idle", k), 0, 15'h0, 0, 0);
    end

    // Asynchronous reset mid-RUN, then wait in IDLE
    step(1, 0, 0); chk("rst_run0", 0, 15'h0, 1, 0);
    step(0, 0, 0); chk("rst_run1", 1, 15'h1, 1, 0);
    step(0, 0, 0); chk("rst_run2", 2, 15'h2, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 0, 15'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0); chk("rst_idle", 0, 15'h0, 0, 0);
    step(0, 0, 0); chk("rst_idle2", 0, 15'h0, 0, 0);

    // Counted loop, start-wait branch, address wrap and final halt hold
    clear_rom();
    rom[0]  = mw(3'd0, 5'd8,  15'h10);
    rom[8]  = mw(3'd6, 5'd0,  15'h18);
    rom[9]  = mw(3'd6, 5'd0,  15'h19);
    rom[10] = mw(3'd4, 5'd8,  15'h1A);
    rom[11] = mw(3'd5, 5'd13, 15'h1B);
    rom[13] = mw(3'd0, 5'd30, 15'h1D);
    rom[30] = mw(3'd6, 5'd0,  15'h1E);
    rom[31] = mw(3'd6, 5'd0,  15'h1F);
    step(1, 0, 0); chk("loop_start", 0, 15'h0, 1, 0);
    for (int i = 0; i < 21; i++) begin
      step(0, 0, 0);
      chk($sformatf("loop[%0d]", i), lp_a[i], lp_c[i], 1, 0);
    end
    step(1, 0, 0); chk("loop_wait_fall", 12, 15'h1B, 1, 0);
    step(1, 0, 0); chk("loop_halt", 12, 15'h0, 0, 1);
    step(1, 0, 0); chk("loop_hold_done", 12, 15'h0, 0, 1);
    step(0, 0, 0); chk("loop_idle", 0, 15'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
